booth_dot_acc: RTL and testbench
================================

# booth_dot_acc

Operand sequencer and accumulator wrapped around the 4-bit sequential Booth multiplier (`BoothMul`).
- Buffers incoming signed 4-bit operand pairs in a small FIFO.
- Issues them one at a time to the multiplier over its start/valid handshake.
- Sums LEN consecutive 8-bit products into one dot-product result.

It sits directly upstream and downstream of the multiplier: it drives `start`/`X`/`Y` and consumes `valid`/`Z`.

## Interface
Parameters:
- DEPTH, 4: operand FIFO entries; power of two, ≥2.
- LEN, 4: products per dot product; ≥1.
- ACC_W, 12: accumulator/result width; must satisfy ACC_W ≥ 8 + clog2(LEN).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; equals !full.
- in_x  in  4  signed operand X.
- in_y  in  4  signed operand Y.
- mul_start  out  1  one-cycle start pulse to multiplier.
- mul_x  out  4  operand X to multiplier.
- mul_y  out  4  operand Y to multiplier.
- mul_valid  in  1  multiplier result-valid pulse.
- mul_z  in  8  signed multiplier product.
- out_valid  out  1  one-cycle pulse; dot product complete.
- out_sum  out  ACC_W  signed dot-product result.
- busy  out  1  high when FSM not IDLE or FIFO non-empty.

## Operation
FIFO:
- Push on in_valid && in_ready.
- Pop only by the FSM in IDLE.
- A push and a pop in the same cycle on a non-empty, non-full FIFO leave the occupancy unchanged.
- When full, in_ready is 0; offered data is not taken.
- There is no bypass: a pair must be written into the FIFO before it can be popped.
- Pointers wrap modulo DEPTH.

FSM states: IDLE, ISSUE, WAIT.
- IDLE: if the FIFO is non-empty, pop the head into the mul_x/mul_y registers and go to ISSUE; otherwise stay.
- ISSUE: mul_start = 1 for exactly this cycle, decoded from the state register. Unconditionally go to WAIT.
- WAIT: hold until mul_valid is sampled 1. On that edge:
  - acc ← acc + sext(mul_z) and pair_cnt ← pair_cnt + 1.
  - If pair_cnt == LEN−1: out_sum ← acc + sext(mul_z), out_valid ← 1 for one cycle, acc ← 0, pair_cnt ← 0.
  - Go to IDLE in either case.

Holding and ignoring rules:
- mul_x/mul_y are held constant from the pop edge until the edge after mul_valid. The multiplier re-reads X bits every cycle while busy, so these registers must not change in the meantime.
- mul_valid is ignored in IDLE and ISSUE.
- mul_start is never asserted outside ISSUE.

Arithmetic:
- mul_z is sign-extended to ACC_W bits.
- The accumulator wraps in two's complement; there is no saturation and no overflow flag.
- out_sum holds its last value until the next completion.

## Timing
Reset values: in_ready = 1, mul_start = 0, mul_x = 0, mul_y = 0, out_valid = 0, out_sum = 0, busy = 0. FIFO empty, acc = 0, pair_cnt = 0, state IDLE.

Reset mid-operation (any state):
- Immediately return to the values above.
- All buffered pairs and the partial sum are discarded.
- The multiplier shares rst, so both blocks restart in lockstep.

Latency:
- Pair pushed at edge E into an empty FIFO, FSM in IDLE: popped at E+1, mul_start high in cycle E+1..E+2, WAIT entered at E+2.
- out_valid asserts in the cycle following the edge that samples the last mul_valid.
- With the Booth multiplier (valid sampled 5 edges after start), each product occupies 7 cycles. Pairs are not overlapped.

Throughput: one multiply in flight at a time. The FIFO absorbs up to DEPTH pairs while a multiply is in flight.

## Test plan
The bench uses a behavioural multiplier model: exact X·Y, mul_valid pulsed 5 edges after mul_start is sampled, X/Y checked stable throughout.
- **Reset:** drive rst = 0 with random inputs → all outputs at their reset values; in_ready = 1; out_valid never pulses.
- **Mixed-sign dot product:** LEN = 4, pairs (1,2), (3,−1), (−2,−3), (7,7) → single out_valid pulse, out_sum = 54 (12'h036); exactly 4 mul_start pulses.
- **Negative sum:** (−8,7) ×4 → out_sum = −224 (12'hF20); acc then 0, so the next group (0,5) ×4 → 0.
- **Backpressure:** in_valid held high with 8 distinct pairs (DEPTH = 4) → in_ready low whenever occupancy = 4. Results: two out_valid pulses, sums match the model, no pair lost or duplicated, issue order preserved.
- **Spurious valid:** a mul_valid pulse injected in IDLE and in ISSUE → accumulator and pair_cnt unchanged; final sum still correct.
- **Mid-operation reset:** rst asserted during WAIT of the 3rd pair → outputs reset. The next 4 pairs (1,1) ×4 → out_sum = 4, with no residue from the aborted group.

Source files
------------

// File: rtl/booth_dot_acc.sv
// rtl/booth_dot_acc.sv - operand FIFO, Booth multiplier sequencer and dot-product accumulator
// Buffers signed 4-bit pairs, issues them one at a time, sums LEN products.
module booth_dot_acc #(
   parameter int DEPTH = 4,
   parameter int LEN   = 4,
   parameter int ACC_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_x,
   input  logic [3:0]       in_y,
   output logic             mul_start,
   output logic [3:0]       mul_x,
   output logic [3:0]       mul_y,
   input  logic             mul_valid,
   input  logic [7:0]       mul_z,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_sum,
   output logic             busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(LEN - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            state;
   logic [7:0]        fifo_mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_next;
   logic [CW-1:0]     pair_cnt;
   logic signed [7:0] z_s;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign pop      = (state == IDLE) && !empty;

   assign mul_start = (state == ISSUE);
   assign busy      = (state != IDLE) || !empty;

   assign z_s      = mul_z;
   assign acc_next = acc + ACC_W'(z_s);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[AW-1:0]] <= {in_x, in_y};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + (AW+1)'(1);
      end
   end

   // mul_x/mul_y only load on a pop, so they stay put for the whole multiply.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         mul_x     <= '0;
         mul_y     <= '0;
         acc       <= '0;
         pair_cnt  <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  {mul_x, mul_y} <= fifo_mem[rd_ptr[AW-1:0]];
                  rd_ptr         <= rd_ptr + (AW+1)'(1);
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (mul_valid) begin
                  if (pair_cnt == LAST) begin
                     out_sum   <= acc_next;
                     out_valid <= 1'b1;
                     acc       <= '0;
                     pair_cnt  <= '0;
                  end else begin
                     acc      <= acc_next;
                     pair_cnt <= pair_cnt + CW'(1);
                  end
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_dot_acc.sv
// tb/tb_booth_dot_acc.sv - directed self-checking bench for booth_dot_acc
// Behavioural multiplier answers 5 edges after start and watches operand stability.
module tb_booth_dot_acc;

   localparam int ACC_W = 12;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_x;
   logic [3:0]       in_y;
   logic             mul_start;
   logic [3:0]       mul_x;
   logic [3:0]       mul_y;
   logic             mul_valid;
   logic [7:0]       mul_z;
   logic             out_valid;
   logic [ACC_W-1:0] out_sum;
   logic             busy;

   logic             mdl_valid = 1'b0;
   logic [7:0]       mdl_z = 8'h00;
   logic             inj_valid = 1'b0;
   logic [7:0]       inj_z = 8'h00;

   int               n_vec = 0;
   int               n_err = 0;
   int               m_cnt = 0;
   int               st_cnt = 0;
   int               hold_err = 0;
   int               stalls = 0;
   logic [3:0]       mx;
   logic [3:0]       my;
   logic [ACC_W-1:0] out_q [$];
   logic [7:0]       iss_q [$];

   always #5 clk = ~clk;

   assign mul_valid = mdl_valid | inj_valid;
   assign mul_z     = mdl_valid ? mdl_z : inj_z;

   booth_dot_acc #(.DEPTH(4), .LEN(4), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .mul_start (mul_start),
      .mul_x     (mul_x),
      .mul_y     (mul_y),
      .mul_valid (mul_valid),
      .mul_z     (mul_z),
      .out_valid (out_valid),
      .out_sum   (out_sum),
      .busy      (busy)
   );

   // Multiplier model: valid is driven so that it is sampled 5 edges after start.
   initial begin
      logic signed [7:0] ex;
      logic signed [7:0] ey;
      forever begin
         @(negedge clk);
         mdl_valid = 1'b0;
         if (!rst) begin
            m_cnt = 0;
         end else begin
            if (m_cnt != 0) begin
               if (mul_x != mx || mul_y != my) hold_err++;
               if (mul_start) hold_err++;
               m_cnt--;
               if (m_cnt == 0) begin
                  ex        = {{4{mx[3]}}, mx};
                  ey        = {{4{my[3]}}, my};
                  mdl_z     = ex * ey;
                  mdl_valid = 1'b1;
               end
            end
            if (mul_start) begin
               m_cnt = 5;
               mx    = mul_x;
               my    = mul_y;
               st_cnt++;
               iss_q.push_back({mul_x, mul_y});
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (out_valid) out_q.push_back(out_sum);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [3:0] x, input logic [3:0] y);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_x     = x;
      in_y     = y;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
         stalls++;
      end
      if (t >= 200) check_eq("push_ready", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic send4(input logic [31:0] pairs);
      for (int i = 3; i >= 0; i--) push(pairs[i*8+4 +: 4], pairs[i*8 +: 4]);
   endtask

   task automatic idle_in();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_outs(input int n);
      int t = 0;
      while (out_q.size() < n && t < 400) begin
         @(negedge clk);
         t++;
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic check_sum(input string tag, input int idx, input logic [ACC_W-1:0] exp);
      if (idx < out_q.size()) check_eq(tag, out_q[idx], exp);
      else                    check_eq(tag, out_q.size(), idx + 1);
   endtask

   task automatic check_iss(input string tag, input int idx, input logic [7:0] exp);
      if (idx < iss_q.size()) check_eq(tag, iss_q[idx], exp);
      else                    check_eq(tag, iss_q.size(), idx + 1);
   endtask

   initial begin
      int base_o;
      int base_s;
      int base_i;
      int seen;
      int t;
      logic [63:0] bp_pairs;

      rst      = 1'b0;
      in_valid = 1'b0;
      in_x     = 4'h0;
      in_y     = 4'h0;

      // Reset held with random activity on every input.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid  = 1'($urandom_range(0, 1));
         in_x      = 4'($urandom);
         in_y      = 4'($urandom);
         inj_valid = 1'($urandom_range(0, 1));
         inj_z     = 8'($urandom);
         #1;
         check_eq("rst_ctrl", {in_ready, mul_start, mul_x, mul_y, out_valid, busy}, 12'h800);
         check_eq("rst_sum", out_sum, 12'h000);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      inj_valid = 1'b0;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_no_out", out_q.size(), 0);
      check_eq("rst_idle", {in_ready, busy}, 2'b10);

      // Mixed-sign dot product: 2 - 3 + 6 + 49 = 54.
      base_o = out_q.size();
      base_s = st_cnt;
      send4(32'h12_3F_ED_77);
      idle_in();
      wait_outs(base_o + 1);
      check_eq("mix_count", out_q.size() - base_o, 1);
      check_sum("mix_sum", base_o, 12'h036);
      check_eq("mix_starts", st_cnt - base_s, 4);

      // Negative sum, then an all-zero group proves the accumulator cleared.
      base_o = out_q.size();
      send4(32'h87_87_87_87);
      send4(32'h05_05_05_05);
      idle_in();
      wait_outs(base_o + 2);
      check_eq("neg_count", out_q.size() - base_o, 2);
      check_sum("neg_sum", base_o, 12'hF20);
      check_sum("zero_sum", base_o + 1, 12'h000);

      // Backpressure: 8 pairs with in_valid held; FIFO fills behind the first multiply.
      base_o   = out_q.size();
      base_i   = iss_q.size();
      stalls   = 0;
      bp_pairs = 64'h11_2D_C5_66_93_58_BA_47;
      for (int i = 7; i >= 0; i--) push(bp_pairs[i*8+4 +: 4], bp_pairs[i*8 +: 4]);
      idle_in();
      check_eq("bp_stalls", stalls, 16);
      wait_outs(base_o + 2);
      check_eq("bp_count", out_q.size() - base_o, 2);
      check_sum("bp_sum0", base_o, 12'h00B);
      check_sum("bp_sum1", base_o + 1, 12'hFFD);
      check_eq("bp_issued", iss_q.size() - base_i, 8);
      for (int i = 0; i < 8; i++) check_iss("bp_order", base_i + i, bp_pairs[(7-i)*8 +: 8]);

      // Spurious valids in IDLE and in ISSUE must be ignored: 6 - 4 - 25 + 9 = -14.
      base_o = out_q.size();
      base_s = st_cnt;
      @(negedge clk);
      inj_z     = 8'h55;
      inj_valid = 1'b1;
      @(negedge clk);
      inj_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("spur_idle_busy", busy, 0);
      fork
         begin
            send4(32'h23_F4_5B_DD);
            idle_in();
         end
         begin
            seen = 0;
            t    = 0;
            while (seen < 2 && t < 400) begin
               @(negedge clk);
               t++;
               if (mul_start) seen++;
            end
            inj_valid = 1'b1;
            @(negedge clk);
            inj_valid = 1'b0;
         end
      join
      wait_outs(base_o + 1);
      check_eq("spur_count", out_q.size() - base_o, 1);
      check_sum("spur_sum", base_o, 12'hFF2);
      check_eq("spur_starts", st_cnt - base_s, 4);

      // Reset during WAIT of the third pair discards the partial sum and FIFO.
      base_o = out_q.size();
      base_s = st_cnt;
      send4(32'h22_33_1F_44);
      idle_in();
      t = 0;
      while (st_cnt < base_s + 3 && t < 400) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      check_eq("mid_busy", busy, 1);
      rst = 1'b0;
      #1;
      check_eq("mid_rst_ctrl", {in_ready, mul_start, mul_x, mul_y, out_valid, busy}, 12'h800);
      check_eq("mid_rst_sum", out_sum, 12'h000);
      repeat (2) @(negedge clk);
      rst    = 1'b1;
      base_s = st_cnt;
      repeat (20) @(negedge clk);
      check_eq("mid_no_issue", st_cnt - base_s, 0);
      check_eq("mid_no_out", out_q.size() - base_o, 0);
      check_eq("mid_idle", busy, 0);
      send4(32'h11_11_11_11);
      idle_in();
      wait_outs(base_o + 1);
      check_eq("post_count", out_q.size() - base_o, 1);
      check_sum("post_sum", base_o, 12'h004);

      check_eq("hold_stable", hold_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
